// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encodings
// and big-endian byte-enable constants.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_WAIT = 2'd1,
        ARB_D_WAIT  = 2'd2
    } arb_state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b1000;

    // Byte lane k of a big-endian word sits at bits [31-8k -: 8].
    function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] lane;
        case (k)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_lane_unit.sv
// Combinational big-endian byte-lane steering: byte enables and replicated
// write data for stores, lane extraction and zero/sign extension for loads.
module byte_lane_unit
    import mem_port_arbiter_pkg::*;
(
    input  logic        is_data,
    input  logic        we,
    input  logic        byte_acc,
    input  logic        signextend,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] load_data
);

    logic       byte_store;
    logic       byte_load;
    logic [7:0] lane;

    assign byte_store = is_data && we && byte_acc;
    assign byte_load  = is_data && !we && byte_acc;
    assign lane       = be_lane(rdata_in, offset);

    always_comb begin
        be        = BE_WORD;
        wdata_out = 32'd0;
        load_data = rdata_in;

        if (byte_store) begin
            be        = BE_B0 >> offset;
            wdata_out = {4{wdata_in[7:0]}};
        end else if (is_data && we) begin
            wdata_out = wdata_in;
        end

        if (byte_load) begin
            load_data = {{24{signextend && lane[7]}}, lane};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and MEM-stage data.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic              d_signextend,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t        state;
    logic              starve_force;
    logic              data_wins;
    logic              data_sel;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] streak;

    // Counts data grants that made a waiting fetch wait again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (grant) begin
            if (data_wins && if_req) begin
                streak <= streak + 4'd1;
            end else begin
                streak <= 4'd0;
            end
        end
    end

    assign starve_force = if_req && (streak >= 4'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif

    assign data_wins = d_req && !starve_force;
    assign mem_req   = (state == ARB_IDLE) && (if_req || d_req);
    assign grant     = mem_req && mem_gnt;

    // While waiting, the owner's held inputs still drive the lane unit so the
    // load offset and extension mode are available when the response lands.
    assign data_sel  = (state == ARB_IDLE) ? data_wins : (state == ARB_D_WAIT);
    assign sel_addr  = data_sel ? d_addr : if_addr;

    byte_lane_unit u_lanes (
        .is_data    (data_sel),
        .we         (d_we),
        .byte_acc   (d_byte),
        .signextend (d_signextend),
        .offset     (sel_addr[1:0]),
        .wdata_in   (d_wdata),
        .rdata_in   (mem_rdata),
        .be         (lane_be),
        .wdata_out  (lane_wdata),
        .load_data  (load_data)
    );

    // One outstanding transaction; ownership is encoded in the wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        state <= data_wins ? ARB_D_WAIT : ARB_IF_WAIT;
                    end
                end
                ARB_IF_WAIT, ARB_D_WAIT: begin
                    if (mem_rvalid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (mem_req) begin
            mem_we    = data_wins && d_we;
            mem_be    = lane_be;
            mem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = lane_wdata;
        end
    end

    assign if_valid = (state == ARB_IF_WAIT) && mem_rvalid;
    assign d_valid  = (state == ARB_D_WAIT) && mem_rvalid;
    assign if_rdata = if_valid ? mem_rdata : 32'd0;
    assign d_rdata  = d_valid ? load_data : 32'd0;
    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

endmodule
